// File: rtl/if_fetch_stage.sv
// if_fetch_stage: PC owner, instruction-memory handshake and IF/ID register, with
// a one-entry hold buffer for stalls and a drain state for redirects under slow memory.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP      = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_shouldStall,
  input  logic        id_shouldJumpOrBranch,
  input  logic [31:0] id_jumpOrBranchPc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  output logic [31:0] pc_4,
  output logic        instructionValid
);
  typedef enum logic [1:0] {FETCH, HOLD, DRAIN} state_t;
  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d, instr_q, instr_d, pc4_q, pc4_d;
  logic [31:0] buf_instr_q, buf_instr_d, buf_pc4_q, buf_pc4_d;
  logic [31:0] redirect_pc_q, redirect_pc_d, pc_inc;
  logic        valid_q, valid_d;
  assign imem_req         = rst & (state_q != HOLD);
  assign imem_addr        = pc_q;
  assign instruction      = instr_q;
  assign pc_4             = pc4_q;
  assign instructionValid = valid_q;
  assign pc_inc           = pc_q + 32'd4;
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    pc4_d         = pc4_q;
    valid_d       = valid_q;
    buf_instr_d   = buf_instr_q;
    buf_pc4_d     = buf_pc4_q;
    redirect_pc_d = redirect_pc_q;
    unique case (state_q)
      FETCH: begin
        if (id_shouldStall) begin
          if (imem_ready) begin
            buf_instr_d = imem_rdata;
            buf_pc4_d   = pc_inc;
            state_d     = HOLD;
          end
        end else if (id_shouldJumpOrBranch) begin
          instr_d = NOP;
          valid_d = 1'b0;
          if (imem_ready) pc_d = id_jumpOrBranchPc;
          else begin
            redirect_pc_d = id_jumpOrBranchPc;
            state_d       = DRAIN;
          end
        end else if (imem_ready) begin
          instr_d = imem_rdata;
          pc4_d   = pc_inc;
          valid_d = 1'b1;
          pc_d    = pc_inc;
        end else begin
          instr_d = NOP;
          valid_d = 1'b0;
        end
      end
      HOLD: begin
        if (!id_shouldStall) begin
          state_d = FETCH;
          instr_d = id_shouldJumpOrBranch ? NOP : buf_instr_q;
          valid_d = !id_shouldJumpOrBranch;
          pc4_d   = id_shouldJumpOrBranch ? pc4_q : buf_pc4_q;
          pc_d    = id_shouldJumpOrBranch ? id_jumpOrBranchPc : buf_pc4_q;
        end
      end
      DRAIN: begin
        // the squashed request must complete before the target can be issued
        instr_d = NOP;
        valid_d = 1'b0;
        if (imem_ready) begin
          pc_d    = redirect_pc_q;
          state_d = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= FETCH;
      pc_q          <= RESET_PC;
      instr_q       <= NOP;
      pc4_q         <= RESET_PC;
      valid_q       <= 1'b0;
      buf_instr_q   <= '0;
      buf_pc4_q     <= '0;
      redirect_pc_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      pc4_q         <= pc4_d;
      valid_q       <= valid_d;
      buf_instr_q   <= buf_instr_d;
      buf_pc4_q     <= buf_pc4_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end
endmodule

// File: doc/if_fetch_stage.md
# if_fetch_stage

Instruction-fetch stage of the five-stage pipeline CPU: owns the PC, drives the instruction-memory request/ready handshake, and loads the IF/ID pipeline register that feeds the decode stage (`instruction`, `pc_4`). It consumes the decode stage's `shouldStall`, `shouldJumpOrBranch` and `jumpOrBranchPc`. Branches and jumps resolve in ID with no delay slot, so the sequential fetch behind a taken redirect is squashed. Variable-latency memory is tolerated through a pending-redirect drain state and a one-entry hold buffer.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.
- `NOP`, default 32'h0000_0000: instruction word loaded into IF/ID as a bubble.

- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `id_shouldStall` in 1: decode stage requests an IF/ID and PC freeze (load-use hazard).
- `id_shouldJumpOrBranch` in 1: decode stage resolved a taken jump or branch this cycle.
- `id_jumpOrBranchPc` in 32: redirect target; valid when `id_shouldJumpOrBranch` = 1.
- `imem_req` out 1: fetch request.
- `imem_addr` out 32: fetch address; always equals `pc`.
- `imem_ready` in 1: memory completes the request this cycle; may be high in the same cycle `imem_req` rises (zero-wait).
- `imem_rdata` in 32: instruction word; valid when `imem_req` = 1 and `imem_ready` = 1.
- `instruction` out 32: IF/ID instruction register.
- `pc_4` out 32: IF/ID register holding fetch address + 4.
- `instructionValid` out 1: IF/ID holds a real instruction (0 = bubble).

## Operation
- Registers: `pc`, IF/ID {`instruction`, `pc_4`, `instructionValid`}, hold buffer {`buf_instr`, `buf_pc4`}, `redirect_pc`, `state` ∈ {FETCH, HOLD, DRAIN}.
- `imem_req` = `rst` & (`state` != HOLD). Once raised, `imem_req` and `imem_addr` stay stable until `imem_ready`.
- Priority in every state: stall > redirect > sequential. A redirect that arrives together with a stall is ignored; decode re-asserts it after the stall clears.
- A "bubble" loads `instruction`=NOP, `instructionValid`=0, and keeps `pc_4` unchanged.
- FETCH:
  - stall, ready: {`buf_instr`, `buf_pc4`} ← {`imem_rdata`, `pc`+4}; go to HOLD. IF/ID and `pc` hold.
  - stall, not ready: all registers hold.
  - redirect, ready: data discarded; IF/ID ← bubble; `pc` ← target; stay in FETCH.
  - redirect, not ready: IF/ID ← bubble; `redirect_pc` ← target; go to DRAIN.
  - ready: IF/ID ← {`imem_rdata`, `pc`+4, 1}; `pc` ← `pc`+4.
  - otherwise: IF/ID ← bubble; `pc` holds.
- HOLD (no request outstanding):
  - stall: all registers hold.
  - redirect: IF/ID ← bubble; buffer discarded; `pc` ← target; go to FETCH.
  - otherwise: IF/ID ← {`buf_instr`, `buf_pc4`, 1}; `pc` ← `buf_pc4`; go to FETCH.
- DRAIN: keeps the old request until `imem_ready`. On ready, data is discarded, `pc` ← `redirect_pc`, go to FETCH. IF/ID stays a bubble each cycle. Decode inputs are ignored, because ID only holds a bubble.
- Arithmetic: PC increment is 32-bit modulo; 32'hFFFF_FFFC + 4 wraps to 0. Targets are taken as given, with no alignment check.

## Timing
- Reset values (asynchronous): `pc`=`RESET_PC`, `instruction`=NOP, `pc_4`=`RESET_PC`, `instructionValid`=0, `state`=FETCH, buffer and `redirect_pc`=0, `imem_req`=0.
- A reset asserted mid-request drops `imem_req` immediately. A response that arrives during reset is ignored.
- With zero-wait memory and no hazards, throughput is 1 instruction per cycle. Fetch of address A sits in IF/ID at the next edge, so latency is 1 cycle.
- With N-cycle memory (ready on the Nth cycle of the request), there are N−1 bubbles per instruction.
- Taken redirect with zero-wait memory: exactly 1 bubble, and the target instruction reaches IF/ID two edges after the redirect cycle.
- Stall: IF/ID is frozen for exactly the stalled cycles, and no instruction is lost or duplicated.

## Test plan
- Reset release, zero-wait memory returning word = address: IF/ID sequence is 0x0,0x4,0x8 with `pc_4` 0x4,0x8,0xC and `instructionValid`=1 from the first edge after release.
- Redirect to 0x100 while fetching 0x8, ready=1: 0x8 is squashed (one bubble), the next valid instruction is 0x100 with `pc_4`=0x104, followed by 0x104.
- Two-cycle stall while fetch 0xC completes: IF/ID holds 0x8 for both cycles, then 0xC, then 0x10; no gaps or repeats.
- 3-cycle memory with a redirect to 0x200 on the first wait cycle of 0x10: `imem_addr` stays 0x10 until ready, 0x10 data is discarded, the next request is 0x200, and IF/ID shows bubbles until 0x200 arrives.
- Stall and redirect together, then redirect alone: the first cycle freezes, the second redirects; HOLD buffer contents are discarded. Separately, `rst` pulsed low mid-request gives `imem_req`=0 at once and fetch restarts at `RESET_PC`.
